bus_sequencer: RTL and testbench

Control sequencer that drives the bus side of the datapath. It generates the one-hot source "out" strobes and the destination "in" strobes that the bus multiplexer and registers consume. It steps fetch (F0–F3) and execute (E0–E3) for register-register, multiply/divide and unary instructions. Bus source strobes are one-hot: never more than one asserted per cycle.

---
 rtl/bus_sequencer.sv | 163 ++++++++++++++++
 tb/tb_bus_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Bus-side control sequencer: steps fetch (F0-F3) and execute (E0-E3) and decodes the bus strobes.
// Optional single-step gating is enabled by defining BUS_SEQUENCER_STEP_EN (adds the step input).
module bus_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear,
`ifdef BUS_SEQUENCER_STEP_EN
  input  logic        step,
`endif
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [4:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic        mem_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_F0, S_F1, S_F2, S_F3, S_E0, S_E1, S_E2, S_E3
  } state_e;

  typedef enum logic [1:0] {C_ALU3, C_MULDIV, C_UNARY, C_ILL} class_e;

  // The counter only ever holds 0..MEM_TIMEOUT-1 before the abort fires.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  class_e           cls;
  logic             adv;
  logic             timeout_hit;
  logic [4:0]       opcode;
  logic [15:0]      sel_ra, sel_rb, sel_rc;
  logic             unused_ir;

`ifdef BUS_SEQUENCER_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  assign opcode    = ir[31:27];
  assign sel_ra    = 16'h0001 << ir[26:23];
  assign sel_rb    = 16'h0001 << ir[22:19];
  assign sel_rc    = 16'h0001 << ir[18:15];
  assign unused_ir = ^ir[14:0];

  assign timeout_hit = (MEM_TIMEOUT != 0) && (state_q == S_F2) && !mem_ready && (cnt_q == TO_LAST);

  always_comb begin
    case (opcode)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: cls = C_ALU3;
      5'd15, 5'd16:                                           cls = C_MULDIV;
      5'd17, 5'd18:                                           cls = C_UNARY;
      default:                                                cls = C_ILL;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0;
    Read = 1'b0; MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; Rout = '0; Rin = '0; alu_op = '0;
    done = 1'b0; illegal = 1'b0; mem_err = 1'b0;
    busy = (state_q != S_IDLE);
    if (adv) begin
      case (state_q)
        S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
        S_F1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; end
        S_F2: begin Read = 1'b1; MDRin = mem_ready; mem_err = timeout_hit; end
        S_F3: begin MDRout = 1'b1; IRin = 1'b1; end
        S_E0: begin
          case (cls)
            C_ALU3:   begin Rout = sel_rb; Yin = 1'b1; end
            C_MULDIV: begin Rout = sel_ra; Yin = 1'b1; end
            C_UNARY:  begin Rout = sel_rb; Zin = 1'b1; alu_op = opcode; end
            default:  illegal = 1'b1;
          endcase
        end
        S_E1: begin
          case (cls)
            C_ALU3:   begin Rout = sel_rc; Zin = 1'b1; alu_op = opcode; end
            C_MULDIV: begin Rout = sel_rb; Zin = 1'b1; alu_op = opcode; end
            C_UNARY:  begin Zlowout = 1'b1; Rin = sel_ra; done = 1'b1; end
            default:  ;
          endcase
        end
        S_E2: begin
          case (cls)
            C_ALU3:   begin Zlowout = 1'b1; Rin = sel_ra; done = 1'b1; end
            C_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
            default:  ;
          endcase
        end
        S_E3: begin Zhighout = 1'b1; HIin = 1'b1; done = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (adv) begin
      case (state_q)
        S_IDLE: if (run) state_d = S_F0;
        S_F0:   state_d = S_F1;
        S_F1:   begin state_d = S_F2; cnt_d = '0; end
        S_F2: begin
          if (mem_ready) begin
            state_d = S_F3;
            cnt_d   = '0;
          end else if (timeout_hit) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_F3:   state_d = S_E0;
        S_E0:   state_d = S_E1;
        S_E1:   state_d = S_E2;
        S_E2:   state_d = S_E3;
        default: state_d = S_IDLE;
      endcase
      // The final cycle of any instruction chains straight into the next fetch while run is high.
      if (done || illegal) state_d = run ? S_F0 : S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus randomized instruction streams
// compared against a strobe-table model; a second instance exercises a short fetch timeout.
module tb_bus_sequencer;

  typedef struct packed {
    logic pc_out, inc_pc, pc_in, mar_in, read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  alu_op;
    logic busy, done, illegal, mem_err;
  } outs_t;

  typedef struct packed {
    outs_t       o;
    logic        mr;
    logic        rn;
    logic [31:0] irv;
  } step_t;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;
  outs_t       act_d, act_t;
  int          n_checks = 0;
  int          n_fail   = 0;
  step_t       q[$];

  always #5 clock = ~clock;

  bus_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(act_d.pc_out), .IncPC(act_d.inc_pc), .PCin(act_d.pc_in), .MARin(act_d.mar_in),
    .Read(act_d.read), .MDRin(act_d.mdr_in), .MDRout(act_d.mdr_out), .IRin(act_d.ir_in),
    .Yin(act_d.y_in), .Zin(act_d.z_in), .Zlowout(act_d.zlow_out), .Zhighout(act_d.zhigh_out),
    .HIin(act_d.hi_in), .LOin(act_d.lo_in), .Rout(act_d.rout), .Rin(act_d.rin),
    .alu_op(act_d.alu_op), .busy(act_d.busy), .done(act_d.done), .illegal(act_d.illegal),
    .mem_err(act_d.mem_err)
  );

  bus_sequencer #(.MEM_TIMEOUT(2)) dut_to (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(act_t.pc_out), .IncPC(act_t.inc_pc), .PCin(act_t.pc_in), .MARin(act_t.mar_in),
    .Read(act_t.read), .MDRin(act_t.mdr_in), .MDRout(act_t.mdr_out), .IRin(act_t.ir_in),
    .Yin(act_t.y_in), .Zin(act_t.z_in), .Zlowout(act_t.zlow_out), .Zhighout(act_t.zhigh_out),
    .HIin(act_t.hi_in), .LOin(act_t.lo_in), .Rout(act_t.rout), .Rin(act_t.rin),
    .alu_op(act_t.alu_op), .busy(act_t.busy), .done(act_t.done), .illegal(act_t.illegal),
    .mem_err(act_t.mem_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void push(input outs_t o, input logic mr, input logic rn, input logic [31:0] irv);
    step_t s;
    s.o = o; s.mr = mr; s.rn = rn; s.irv = irv;
    q.push_back(s);
  endfunction

  function automatic void push_idle(input logic rn, input logic [31:0] irv);
    push('0, 1'b0, rn, irv);
  endfunction

  // Model: the strobe table for one instruction, with wait_n not-ready cycles in F2.
  function automatic void build(input logic [31:0] irv, input int wait_n, input int to, input logic rn_last);
    outs_t o;
    step_t s;
    logic [4:0]  op = irv[31:27];
    logic [15:0] ra = 16'h0001 << irv[26:23];
    logic [15:0] rb = 16'h0001 << irv[22:19];
    logic [15:0] rc = 16'h0001 << irv[18:15];
    o = '0; o.busy = 1; o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1;
    push(o, 0, 1'($urandom_range(0, 1)), irv);
    o = '0; o.busy = 1; o.zlow_out = 1; o.pc_in = 1; o.read = 1;
    push(o, 0, 1'($urandom_range(0, 1)), irv);
    for (int k = 0; ; k++) begin
      o = '0; o.busy = 1; o.read = 1;
      if (k == wait_n) begin
        o.mdr_in = 1;
        push(o, 1, 1'($urandom_range(0, 1)), irv);
        break;
      end
      if (to != 0 && k == to - 1) begin
        o.mem_err = 1;
        push(o, 0, rn_last, irv);
        return;
      end
      push(o, 0, 1'($urandom_range(0, 1)), irv);
    end
    o = '0; o.busy = 1; o.mdr_out = 1; o.ir_in = 1;
    push(o, 0, 1'($urandom_range(0, 1)), irv);
    if (op inside {[5'd3:5'd11]}) begin
      o = '0; o.busy = 1; o.rout = rb; o.y_in = 1; push(o, 0, 1'($urandom_range(0, 1)), irv);
      o = '0; o.busy = 1; o.rout = rc; o.z_in = 1; o.alu_op = op; push(o, 0, 1'($urandom_range(0, 1)), irv);
      o = '0; o.busy = 1; o.zlow_out = 1; o.rin = ra; o.done = 1; push(o, 0, 1'b0, irv);
    end else if (op == 5'd15 || op == 5'd16) begin
      o = '0; o.busy = 1; o.rout = ra; o.y_in = 1; push(o, 0, 1'($urandom_range(0, 1)), irv);
      o = '0; o.busy = 1; o.rout = rb; o.z_in = 1; o.alu_op = op; push(o, 0, 1'($urandom_range(0, 1)), irv);
      o = '0; o.busy = 1; o.zlow_out = 1; o.lo_in = 1; push(o, 0, 1'($urandom_range(0, 1)), irv);
      o = '0; o.busy = 1; o.zhigh_out = 1; o.hi_in = 1; o.done = 1; push(o, 0, 1'b0, irv);
    end else if (op == 5'd17 || op == 5'd18) begin
      o = '0; o.busy = 1; o.rout = rb; o.z_in = 1; o.alu_op = op; push(o, 0, 1'($urandom_range(0, 1)), irv);
      o = '0; o.busy = 1; o.zlow_out = 1; o.rin = ra; o.done = 1; push(o, 0, 1'b0, irv);
    end else begin
      o = '0; o.busy = 1; o.illegal = 1; push(o, 0, 1'b0, irv);
    end
    s = q.pop_back();
    s.rn = rn_last;
    q.push_back(s);
  endfunction

  task automatic cycle(input step_t s, input bit use_to, input string tag);
    outs_t a;
    int    hot;
    @(posedge clock);
    #1;
    run = s.rn; mem_ready = s.mr; ir = s.irv;
    @(negedge clock);
    a = use_to ? act_t : act_d;
    check(tag, 64'(a), 64'(s.o));
    hot = $countones(a.rout) + int'(a.pc_out) + int'(a.mdr_out) + int'(a.zlow_out) + int'(a.zhigh_out);
    check({tag, "_onehot"}, 64'(hot <= 1), 64'(1));
  endtask

  task automatic play(input int n, input bit use_to, input string tag);
    for (int i = 0; i < n && q.size() > 0; i++) cycle(q.pop_front(), use_to, tag);
  endtask

  task automatic reset_pulse();
    @(posedge clock);
    #1;
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    q.delete();
  endtask

  localparam logic [31:0] ADD_IR = 32'h18918000;
  localparam logic [31:0] MUL_IR = {5'b01111, 4'd4, 4'd5, 4'd0, 15'd0};
  localparam logic [31:0] ILL_IR = {5'b11111, 4'd6, 4'd7, 4'd8, 15'd0};
  localparam logic [31:0] NEG_IR = {5'b10001, 4'd7, 4'd9, 4'd0, 15'd0};

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [4:0]  legal [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                                5'd15, 5'd16, 5'd17, 5'd18};
    logic [31:0] irv;
    logic [4:0]  op;
    logic        rn_last;
    bit          idle;
    int          wait_n;
    step_t       last;

    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
    repeat (2) @(negedge clock);
    check("reset_outs", 64'(act_d), 64'(0));
    check("reset_outs_to", 64'(act_t), 64'(0));
    clear = 1'b0;

    // Abandon an instruction stuck in F2 with an asynchronous clear.
    push_idle(1, ADD_IR);
    build(ADD_IR, 10, 15, 1'b0);
    play(4, 0, "pre_clear");
    @(posedge clock);
    #1;
    clear = 1'b1; run = 1'b0;
    @(negedge clock);
    check("clear_mid_f2", 64'(act_d), 64'(0));
    clear = 1'b0;
    q.delete();

    // add, mul with a memory wait, illegal chaining into F0, then neg.
    push_idle(1, ADD_IR);
    build(ADD_IR, 0, 15, 1'b1);
    build(MUL_IR, 3, 15, 1'b1);
    build(ILL_IR, 0, 15, 1'b1);
    build(NEG_IR, 1, 15, 1'b0);
    push_idle(0, NEG_IR);
    play(q.size(), 0, "directed");

    reset_pulse();
    push_idle(1, ADD_IR);
    build(ADD_IR, 100, 2, 1'b1);
    push_idle(0, ADD_IR);
    play(q.size(), 1, "timeout2");

    reset_pulse();
    push_idle(1, MUL_IR);
    build(MUL_IR, 1, 2, 1'b0);
    push_idle(0, MUL_IR);
    play(q.size(), 1, "timeout2_edge");

    reset_pulse();
    push_idle(1, ADD_IR);
    build(ADD_IR, 100, 15, 1'b0);
    push_idle(0, ADD_IR);
    play(q.size(), 0, "timeout15");

    reset_pulse();
    idle = 1;
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : legal[$urandom_range(0, 12)];
      irv = {op, 27'($urandom)};
      wait_n = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      rn_last = 1'($urandom_range(0, 1));
      if (idle) begin
        push_idle(0, irv);
        push_idle(1, irv);
      end
      build(irv, wait_n, 15, rn_last);
      last = q[q.size() - 1];
      idle = last.o.mem_err || !rn_last;
      play(q.size(), 0, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
